clocked_sample_differencer: RTL and testbench
=============================================

# clocked_sample_differencer

Streaming lag-K differencer: for each accepted signed sample x[n] it produces the registered difference d[n] = x[n] − x[n−LAG], one bit wider than the input so the result never overflows. It is the decoding counterpart of the clocked adder datapath. The adder accumulates or combines samples; this block recovers sample-to-sample deltas, the slope feature, for the spike-detection front end ahead of the decision-tree comparators. Output is registered with one cycle of latency.

## Interface
- IN_WIDTH, 11, width of the signed input sample.
- LAG, 4, difference distance in accepted samples; legal range 1..16.

- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-low; asserted when 0, sampled on the clk rising edge.
- clear  input  1  synchronous history flush, active-high.
- in_valid  input  1  in_sample is accepted this cycle.
- in_sample  input  IN_WIDTH  signed sample x[n].
- out_valid  output  1  one-cycle strobe: out_diff holds a new difference.
- out_diff  output  IN_WIDTH+1  signed d[n] = x[n] − x[n−LAG].
- primed  output  1  high once LAG samples of history are held.

## Operation
- History is a LAG-deep signed delay line, hist[0] newest to hist[LAG−1] oldest. It shifts only on accepted samples: hist[0] ← in_sample, hist[i] ← hist[i−1]. It never shifts on idle cycles.
- fill_cnt counts 0..LAG and saturates at LAG. primed = (fill_cnt == LAG).
- On an accepted sample:
  - If primed (evaluated before this sample): out_diff ← sext(in_sample) − sext(hist[LAG−1]) and out_valid ← 1.
  - Otherwise: no output, out_valid ← 0, and fill_cnt increments.
- Every cycle without an emitting accept drives out_valid ← 0. out_diff holds its last value.
- Arithmetic: both operands are sign-extended to IN_WIDTH+1 before subtracting. The full range fits with no saturation. For IN_WIDTH = 11 the extremes are 1023 − (−1024) = 2047 and −1024 − 1023 = −2047.
- clear = 1:
  - hist entries ← 0, fill_cnt ← 0, out_valid ← 0; out_diff holds.
  - clear beats in_valid in the same cycle: that sample is dropped and is not entered into history.
- reset = 0:
  - hist ← 0, fill_cnt ← 0, out_valid ← 0, out_diff ← 0, primed ← 0.
  - reset beats clear and in_valid.
  - Reset mid-stream discards all history. The first output after release needs LAG+1 new accepts.
- No backpressure: every in_valid sample is consumed. The maximum rate is one sample per cycle.

## Timing
- Reset values: out_valid = 0, out_diff = 0, primed = 0.
- Latency: in_valid at edge k → out_valid and out_diff visible after edge k+1, i.e. one cycle.
- Output strobe rate: out_valid is high for exactly one cycle per emitting accept. With back-to-back inputs it stays high continuously.
- Priming:
  - After reset or clear, the first LAG accepts produce no output.
  - primed rises in the cycle after the LAG-th accept.
  - The (LAG+1)-th accept is the first to emit.
- Gaps in in_valid do not age the history. The difference is always in accepted-sample distance, never in clock cycles.
- A clear that arrives in the same cycle as the final priming accept leaves primed = 0.

## Test plan
- Ramp, back-to-back: LAG=4, in_sample = 0,1,2,… on consecutive cycles.
  - First out_valid comes one cycle after the 5th sample, with out_diff = 4.
  - It then stays 4 every cycle.
  - primed rises after the 4th sample.
- Extremes: LAG=1, IN_WIDTH=11.
  - Sequence −1024, 1023 → out_diff = 2047.
  - Sequence 1023, −1024 → out_diff = −2047.
  - Both are exact, with no wrap.
- Gapped input: LAG=2, samples 10, 30, 70 with 3 idle cycles between each.
  - Single out_valid pulse one cycle after the 70 is accepted, out_diff = 60.
  - out_diff holds 60 afterwards while out_valid = 0.
- Clear mid-stream: LAG=2, stream primed, then clear asserted together with in_valid (sample 99).
  - 99 is dropped, primed → 0, no out_valid that cycle.
  - Next samples 5, 8, 20 → one output, out_diff = 15.
- Reset mid-stream: assert reset = 0 for one cycle while out_valid = 1.
  - Next cycle: out_valid = 0, out_diff = 0, primed = 0.
  - The LAG+1 accepts after release are needed before out_valid.
- Ramp repeated at LAG=16: first output only on the 17th accept, out_diff = 16.

Source files
------------

// File: rtl/clocked_sample_differencer_if.sv
// Sample-stream bundle for the lag-K differencer: producer-driven sample/flush
// strobes plus the registered difference stream coming back.
interface clocked_sample_differencer_if #(
  parameter int IN_WIDTH = 11
);
  // Valid-only stream, no ready: a sample is consumed on every cycle in_valid is
  // high, and out_valid is a one-cycle strobe that must be taken when it appears.
  logic                       clear;
  logic                       in_valid;
  logic signed [IN_WIDTH-1:0] in_sample;
  logic                       out_valid;
  logic signed [IN_WIDTH:0]   out_diff;
  logic                       primed;

  modport master (
    output clear, in_valid, in_sample,
    input  out_valid, out_diff, primed
  );

  modport slave (
    input  clear, in_valid, in_sample,
    output out_valid, out_diff, primed
  );
endinterface

// File: rtl/clocked_sample_differencer.sv
// Streaming lag-K differencer: d[n] = x[n] - x[n-LAG] over accepted samples,
// one bit wider than the input and registered with one cycle of latency.
module clocked_sample_differencer #(
  parameter int IN_WIDTH = 11,
  parameter int LAG      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  clocked_sample_differencer_if.slave  bus
);
  localparam int CNT_W = $clog2(LAG + 1);
  localparam logic [CNT_W-1:0] LAG_CNT = CNT_W'(LAG);

  logic signed [IN_WIDTH-1:0] hist_q [LAG];
  logic signed [IN_WIDTH-1:0] hist_d [LAG];
  logic [CNT_W-1:0]           fill_q, fill_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [IN_WIDTH:0]   out_diff_q, out_diff_d;
  logic                       primed_now;
  logic signed [IN_WIDTH:0]   new_ext, old_ext;

  assign primed_now = (fill_q == LAG_CNT);
  assign new_ext    = {bus.in_sample[IN_WIDTH-1], bus.in_sample};
  assign old_ext    = {hist_q[LAG-1][IN_WIDTH-1], hist_q[LAG-1]};

  always_comb begin
    hist_d      = hist_q;
    fill_d      = fill_q;
    out_valid_d = 1'b0;
    out_diff_d  = out_diff_q;
    if (bus.clear) begin
      // Flush wins over a coincident sample: that sample never enters history.
      for (int i = 0; i < LAG; i++) hist_d[i] = '0;
      fill_d = '0;
    end else if (bus.in_valid) begin
      hist_d[0] = bus.in_sample;
      for (int i = 1; i < LAG; i++) hist_d[i] = hist_q[i-1];
      if (primed_now) begin
        out_diff_d  = new_ext - old_ext;
        out_valid_d = 1'b1;
      end else begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LAG; i++) hist_q[i] <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_diff_q  <= '0;
    end else begin
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_diff_q  <= out_diff_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_diff  = out_diff_q;
  assign bus.primed    = primed_now;
endmodule

// File: tb/tb_clocked_sample_differencer.sv
// Drives one shared sample stream into four differencers (LAG 1, 2, 4, 16) and
// checks each against a queue-based model of "sample minus the one LAG accepts ago".
module tb_clocked_sample_differencer;
  localparam int IW = 11;
  localparam int NL = 4;

  function automatic int lag_of(input int lane);
    case (lane)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  // clock / reset / shared stimulus
  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clear;
  logic                 in_valid;
  logic signed [IW-1:0] in_sample;

  always #5 clk = ~clk;

  logic [NL-1:0]        mv;
  logic [NL-1:0]        mp;
  logic signed [IW:0]   md [NL];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    clocked_sample_differencer_if #(.IN_WIDTH(IW)) ifc ();
    assign ifc.clear     = clear;
    assign ifc.in_valid  = in_valid;
    assign ifc.in_sample = in_sample;
    clocked_sample_differencer #(.IN_WIDTH(IW), .LAG(lag_of(g))) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
    );
    assign mv[g] = ifc.out_valid;
    assign md[g] = ifc.out_diff;
    assign mp[g] = ifc.primed;
  end

  // reference model: accepted-sample history per lane, expected diffs queue
  int hist_q [NL][$];
  int exp_q  [NL][$];
  int held   [NL];
  bit prm    [NL];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_step(input bit rn, input bit cl, input bit v, input int s);
    for (int l = 0; l < NL; l++) begin
      if (!rn) begin
        hist_q[l].delete();
        held[l] = 0;
        prm[l]  = 1'b0;
      end else if (cl) begin
        hist_q[l].delete();
        prm[l] = 1'b0;
      end else if (v) begin
        if (hist_q[l].size() == lag_of(l)) begin
          held[l] = s - hist_q[l][0];
          exp_q[l].push_back(held[l]);
          void'(hist_q[l].pop_front());
        end
        hist_q[l].push_back(s);
        prm[l] = (hist_q[l].size() == lag_of(l));
      end
    end
  endtask

  task automatic drive(input bit rn, input bit cl, input bit v, input int s);
    @(posedge clk);
    #2;
    reset     = rn;
    clear     = cl;
    in_valid  = v;
    in_sample = s[IW-1:0];
    model_step(rn, cl, v, s);
  endtask

  task automatic push(input int s);  drive(1'b1, 1'b0, 1'b1, s); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 0);
  endtask

  // monitor / scoreboard
  always begin
    @(posedge clk);
    #1;
    for (int l = 0; l < NL; l++) begin
      n_cmp++;
      if (mv[l]) begin
        if (exp_q[l].size() == 0) begin
          n_bad++;
          $display("FAIL lane%0d(LAG=%0d) unexpected_valid: got out_valid=1 diff=%0d, expected no output @%0t",
                   l, lag_of(l), md[l], $time);
        end else begin
          int e;
          e = exp_q[l].pop_front();
          if (int'(md[l]) != e) begin
            n_bad++;
            $display("FAIL lane%0d(LAG=%0d) out_diff: got %0d expected %0d @%0t",
                     l, lag_of(l), md[l], e, $time);
          end
        end
      end else if (exp_q[l].size() != 0) begin
        n_bad++;
        $display("FAIL lane%0d(LAG=%0d) missing_valid: got out_valid=0 expected diff %0d @%0t",
                 l, lag_of(l), exp_q[l][0], $time);
        void'(exp_q[l].pop_front());
      end
      n_cmp++;
      if (int'(md[l]) != held[l]) begin
        n_bad++;
        $display("FAIL lane%0d(LAG=%0d) held_diff: got %0d expected %0d @%0t",
                 l, lag_of(l), md[l], held[l], $time);
      end
      n_cmp++;
      if (mp[l] != prm[l]) begin
        n_bad++;
        $display("FAIL lane%0d(LAG=%0d) primed: got %0b expected %0b @%0t",
                 l, lag_of(l), mp[l], prm[l], $time);
      end
    end
  end

  initial begin
    reset     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 5);
    idle(2);

    // back-to-back ramp, long enough for the LAG=16 lane to emit repeatedly
    for (int i = 0; i < 40; i++) push(i);
    idle(2);

    // reset mid-stream while outputs are streaming, then re-prime
    for (int i = 0; i < 6; i++) push(100 + 3 * i);
    drive(1'b0, 1'b0, 1'b1, 7);
    for (int i = 0; i < 20; i++) push(50 - 2 * i);
    idle(2);

    // extremes: full-range differences with no wrap
    drive(1'b0, 1'b0, 1'b0, 0);
    push(-1024); push(1023); push(-1024); push(1023); push(1023); push(-1024);
    idle(2);

    // gapped input: history only ages on accepts
    drive(1'b1, 1'b1, 1'b0, 0);
    push(10); idle(3); push(30); idle(3); push(70); idle(4);

    // clear together with a sample, then re-prime
    drive(1'b1, 1'b1, 1'b0, 0);
    push(1); push(2); push(3);
    drive(1'b1, 1'b1, 1'b1, 99);
    push(5); push(8); push(20);
    idle(3);

    // clear coinciding with the final priming accept
    drive(1'b1, 1'b1, 1'b0, 0);
    push(4);
    drive(1'b1, 1'b1, 1'b1, 6);
    push(11); push(13);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      bit rn, cl, v;
      int s;
      rn = ($urandom_range(0, 127) != 0);
      cl = ($urandom_range(0, 63) == 0);
      v  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       s = -1024;
        1:       s = 1023;
        default: s = int'($urandom_range(0, 2047)) - 1024;
      endcase
      drive(rn, cl, v, s);
    end
    idle(4);

    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
